approx_adder_err_monitor: RTL and testbench

//  Consumer side of the approximate ripple-carry adders (W-bit operands, W+1-bit sum).

---
 rtl/approx_adder_err_monitor.sv | 153 +++++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// Error-statistics monitor for approximate adders: recomputes the exact sum of each
// accepted sample and accumulates count, sum |e|, sum e^2 and max |e| over a run.
module approx_adder_err_monitor #(
  parameter int unsigned W         = 8,
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned ACC_W     = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_approx,
  output logic             busy,
  output logic             done,
  output logic [31:0]      err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [ACC_W-1:0] sum_sq_err,
  output logic [W:0]       max_abs_err,
  output logic [31:0]      sample_cnt
);

  localparam int unsigned W1    = W + 1;
  localparam int unsigned W2    = W + 2;
  localparam int unsigned SQ_W  = 2 * W + 2;
  localparam int unsigned SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              s1_vld_q, s1_vld_d;
  logic [W:0]        abs_q, abs_d;
  logic              ne_q, ne_d;
  logic [31:0]       err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0]  sum_abs_q, sum_abs_d;
  logic [ACC_W-1:0]  sum_sq_q, sum_sq_d;
  logic [W:0]        max_q, max_d;
  logic [31:0]       smp_q, smp_d;

  logic              accept_c;
  logic [W:0]        exact_c;
  logic [W+1:0]      diff_c;
  logic [W:0]        abs_c;
  logic [SQ_W-1:0]   sq_c;
  logic [SUM_W-1:0]  abs_sum_c;
  logic [SUM_W-1:0]  sq_sum_c;

  // Stage-1 datapath: exact sum and magnitude of the signed error
  always_comb begin
    accept_c  = in_valid & in_ready_q;
    exact_c   = W1'(in_a) + W1'(in_b);
    diff_c    = W2'(in_approx) - W2'(exact_c);
    abs_c     = diff_c[W1] ? W1'(-diff_c) : diff_c[W:0];
    sq_c      = SQ_W'(abs_q) * SQ_W'(abs_q);
    abs_sum_c = SUM_W'(sum_abs_q) + SUM_W'(abs_q);
    sq_sum_c  = SUM_W'(sum_sq_q) + SUM_W'(sq_c);
  end

  always_comb begin
    state_d   = state_q;
    s1_vld_d  = accept_c;
    abs_d     = abs_q;
    ne_d      = ne_q;
    err_cnt_d = err_cnt_q;
    sum_abs_d = sum_abs_q;
    sum_sq_d  = sum_sq_q;
    max_d     = max_q;
    smp_d     = smp_q;

    if (accept_c) begin
      abs_d = abs_c;
      ne_d  = |diff_c;
      smp_d = smp_q + 32'd1;
    end

    // Stage 2: accumulate, holding all-ones once an accumulator would overflow
    if (s1_vld_q) begin
      err_cnt_d = err_cnt_q + 32'(ne_q);
      sum_abs_d = (|abs_sum_c[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : abs_sum_c[ACC_W-1:0];
      sum_sq_d  = (|sq_sum_c[SUM_W-1:ACC_W])  ? {ACC_W{1'b1}} : sq_sum_c[ACC_W-1:0];
      if (abs_q > max_q) max_d = abs_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          err_cnt_d = '0;
          sum_abs_d = '0;
          sum_sq_d  = '0;
          max_d     = '0;
          smp_d     = '0;
        end
      end
      RUN: begin
        if (accept_c && (smp_q == 32'(N_SAMPLES - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1_vld_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      abs_q      <= '0;
      ne_q       <= 1'b0;
      err_cnt_q  <= '0;
      sum_abs_q  <= '0;
      sum_sq_q   <= '0;
      max_q      <= '0;
      smp_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s1_vld_q   <= s1_vld_d;
      abs_q      <= abs_d;
      ne_q       <= ne_d;
      err_cnt_q  <= err_cnt_d;
      sum_abs_q  <= sum_abs_d;
      sum_sq_q   <= sum_sq_d;
      max_q      <= max_d;
      smp_q      <= smp_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_cnt_q;
  assign sum_abs_err = sum_abs_q;
  assign sum_sq_err  = sum_sq_q;
  assign max_abs_err = max_q;
  assign sample_cnt  = smp_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed bench: five monitor instances with different N_SAMPLES/ACC_W, checked
// against hand-computed statistics.
module tb_approx_adder_err_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic [8:0] in_approx;
  logic       start [5];

  logic        rdy [5];
  logic        bsy [5];
  logic        dn  [5];
  logic [31:0] errc [5];
  logic [31:0] smp  [5];
  logic [39:0] sabs [5];
  logic [39:0] ssq  [5];
  logic [8:0]  mx   [5];
  logic [19:0] sabs20, ssq20;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_adder_err_monitor #(.W(8), .N_SAMPLES(4), .ACC_W(40)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(bsy[0]), .done(dn[0]),
    .err_count(errc[0]), .sum_abs_err(sabs[0]), .sum_sq_err(ssq[0]),
    .max_abs_err(mx[0]), .sample_cnt(smp[0]));

  approx_adder_err_monitor #(.W(8), .N_SAMPLES(1), .ACC_W(40)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(bsy[1]), .done(dn[1]),
    .err_count(errc[1]), .sum_abs_err(sabs[1]), .sum_sq_err(ssq[1]),
    .max_abs_err(mx[1]), .sample_cnt(smp[1]));

  approx_adder_err_monitor #(.W(8), .N_SAMPLES(5), .ACC_W(20)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(bsy[2]), .done(dn[2]),
    .err_count(errc[2]), .sum_abs_err(sabs20), .sum_sq_err(ssq20),
    .max_abs_err(mx[2]), .sample_cnt(smp[2]));

  assign sabs[2] = 40'(sabs20);
  assign ssq[2]  = 40'(ssq20);

  approx_adder_err_monitor #(.W(8), .N_SAMPLES(3), .ACC_W(40)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(bsy[3]), .done(dn[3]),
    .err_count(errc[3]), .sum_abs_err(sabs[3]), .sum_sq_err(ssq[3]),
    .max_abs_err(mx[3]), .sample_cnt(smp[3]));

  approx_adder_err_monitor #(.W(8), .N_SAMPLES(256), .ACC_W(40)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[4]), .in_valid(in_valid), .in_ready(rdy[4]),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(bsy[4]), .done(dn[4]),
    .err_count(errc[4]), .sum_abs_err(sabs[4]), .sum_sq_err(ssq[4]),
    .max_abs_err(mx[4]), .sample_cnt(smp[4]));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [8:0]  apx;
    logic [31:0] exp_err;
    logic [39:0] exp_abs;
    logic [39:0] exp_sq;
    logic [8:0]  exp_max;
    logic [31:0] exp_smp;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input int id);
    start[id] = 1'b1;
    tick();
    start[id] = 1'b0;
  endtask

  // Present one sample to instance id; it is taken on the next edge with ready high
  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b,
                      input logic [8:0] apx, input int gap);
    int t;
    in_a      = a;
    in_b      = b;
    in_approx = apx;
    in_valid  = 1'b1;
    t = 0;
    while (!rdy[id] && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk($sformatf("ready_timeout_%0d", id), 64'(rdy[id]), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input int id);
    int t;
    t = 0;
    while (!dn[id] && t < 50) begin
      tick();
      t++;
    end
    chk($sformatf("done_wait_%0d", id), 64'(dn[id]), 64'd1);
  endtask

  task automatic chk_stats(input int id, input string tag, input logic [31:0] e,
                           input logic [39:0] sa, input logic [39:0] sq,
                           input logic [8:0] m, input logic [31:0] s);
    chk($sformatf("%s_err_count", tag), 64'(errc[id]), 64'(e));
    chk($sformatf("%s_sum_abs", tag), 64'(sabs[id]), 64'(sa));
    chk($sformatf("%s_sum_sq", tag), 64'(ssq[id]), 64'(sq));
    chk($sformatf("%s_max_abs", tag), 64'(mx[id]), 64'(m));
    chk($sformatf("%s_sample_cnt", tag), 64'(smp[id]), 64'(s));
  endtask

  task automatic chk_flags(input int id, input string tag, input logic r,
                           input logic b, input logic d);
    chk($sformatf("%s_in_ready", tag), 64'(rdy[id]), 64'(r));
    chk($sformatf("%s_busy", tag), 64'(bsy[id]), 64'(b));
    chk($sformatf("%s_done", tag), 64'(dn[id]), 64'(d));
  endtask

  initial begin
    vecs[0] = '{8'd1,   8'd1,   9'd1,   32'd1, 40'd1, 40'd1, 9'd1, 32'd1};
    vecs[1] = '{8'd0,   8'd0,   9'd0,   32'd1, 40'd1, 40'd1, 9'd1, 32'd2};
    vecs[2] = '{8'd3,   8'd1,   9'd3,   32'd2, 40'd2, 40'd2, 9'd1, 32'd3};
    vecs[3] = '{8'd255, 8'd255, 9'd509, 32'd3, 40'd3, 40'd3, 9'd1, 32'd4};

    for (int i = 0; i < 5; i++) start[i] = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_approx = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    chk_flags(0, "reset", 1'b0, 1'b0, 1'b0);
    chk_stats(0, "reset", 32'd0, 40'd0, 40'd0, 9'd0, 32'd0);

    // Test 1: table-driven, cumulative stats after each sample
    pulse_start(0);
    chk_flags(0, "t1_start", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(0, vecs[i].a, vecs[i].b, vecs[i].apx, 1);
      chk_stats(0, $sformatf("t1_v%0d", i), vecs[i].exp_err, vecs[i].exp_abs,
                vecs[i].exp_sq, vecs[i].exp_max, vecs[i].exp_smp);
    end
    wait_done(0);
    chk_flags(0, "t1_end", 1'b0, 1'b0, 1'b1);
    chk_stats(0, "t1_end", 32'd3, 40'd3, 40'd3, 9'd1, 32'd4);

    // Test 2: maximum negative error
    pulse_start(1);
    send(1, 8'd255, 8'd255, 9'd0, 0);
    wait_done(1);
    chk_stats(1, "t2", 32'd1, 40'd510, 40'd260100, 9'd510, 32'd1);

    // Test 3: sum_sq saturation with ACC_W=20
    pulse_start(2);
    for (int i = 0; i < 5; i++) send(2, 8'd255, 8'd255, 9'd0, 0);
    wait_done(2);
    chk_stats(2, "t3", 32'd5, 40'd2550, 40'd1048575, 9'd510, 32'd5);

    // Test 4: in_valid held high, start during DRAIN ignored
    pulse_start(3);
    in_a = 8'd1; in_b = 8'd2; in_approx = 9'd3;
    in_valid = 1'b1;
    tick();
    chk("t4_ready_acc1", 64'(rdy[3]), 64'd1);
    tick();
    chk("t4_ready_acc2", 64'(rdy[3]), 64'd1);
    tick();
    chk_flags(3, "t4_acc3", 1'b0, 1'b1, 1'b0);
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    chk_flags(3, "t4_drain", 1'b0, 1'b1, 1'b0);
    tick();
    chk_flags(3, "t4_done", 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    chk_stats(3, "t4", 32'd0, 40'd0, 40'd0, 9'd0, 32'd3);
    in_valid = 1'b0;

    // Start coinciding with DRAIN->DONE lands in DONE
    pulse_start(3);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    chk_flags(3, "t4b_done", 1'b0, 1'b0, 1'b1);
    tick();
    chk_flags(3, "t4b_hold", 1'b0, 1'b0, 1'b1);

    // Test 5: exact adder with random bubbles
    pulse_start(4);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(4, ra, rb, 9'(ra) + 9'(rb), int'($urandom_range(0, 2)));
    end
    wait_done(4);
    chk_stats(4, "t5", 32'd0, 40'd0, 40'd0, 9'd0, 32'd256);

    // Test 6: reset mid-run, then a clean run
    pulse_start(0);
    send(0, 8'd255, 8'd255, 9'd0, 0);
    send(0, 8'd255, 8'd255, 9'd0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_flags(0, "t6_rst", 1'b0, 1'b0, 1'b0);
    chk_stats(0, "t6_rst", 32'd0, 40'd0, 40'd0, 9'd0, 32'd0);
    tick();
    chk_stats(0, "t6_rst2", 32'd0, 40'd0, 40'd0, 9'd0, 32'd0);
    pulse_start(0);
    for (int i = 0; i < 4; i++) send(0, 8'd1, 8'd1, 9'd1, 0);
    wait_done(0);
    chk_stats(0, "t6_run", 32'd4, 40'd4, 40'd4, 9'd1, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
